// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the registered one-hot scan decoder.
// The one-hot helper is sized for the widest supported output; callers truncate.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam int unsigned MAX_LINES = 256;

    // Returns all zeros when idx falls outside the used lines, so an
    // out-of-range capture naturally produces the all-inactive pattern.
    function automatic logic [MAX_LINES-1:0] onehot(input int unsigned idx,
                                                    input int unsigned width);
        logic [MAX_LINES-1:0] v;
        v = '0;
        if ((idx < width) && (idx < MAX_LINES)) begin
            v = MAX_LINES'(1) << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/scan_step_counter.sv
// Scan timebase: divides the clock by DIV and walks sel over 0..OUTS-1.
// sel_nxt lets the parent register a decoded output aligned with sel.
module scan_step_counter #(
    parameter int DIV   = 4,
    parameter int OUTS  = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    output logic [SEL_W-1:0] sel,
    output logic [SEL_W-1:0] sel_nxt,
    output logic             step
);

    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DCW-1:0]   DIV_LAST = DCW'(DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(OUTS - 1);

    logic [DCW-1:0]   div_cnt_q;
    logic [DCW-1:0]   div_cnt_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        sel_d     = sel_q;
        if (clear) begin
            div_cnt_d = '0;
            sel_d     = '0;
        end else if (en) begin
            // Both counters wrap on explicit compares, never on overflow.
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                sel_d     = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            sel_q     <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sel_q     <= sel_d;
        end
    end

    assign sel     = sel_q;
    assign sel_nxt = sel_d;
    assign step    = en && !clear && (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with a direct (handshaked) mode and a
// self-timed scan mode. Handshake: a is taken on an edge where in_valid && in_ready.
module scan_decoder
    import decoder_pkg::*;
#(
    parameter int N          = 3,
    parameter int OUTS       = 2 ** N,
    parameter int DIV        = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      a,
    output logic [2**N-1:0]   y,
    output logic [N-1:0]      sel,
    output logic              out_valid,
    output logic              err,
    output logic              step,
    output logic [1:0]        dbg_state
);

    localparam int Y_W = 2 ** N;
    localparam int unsigned OUTS_U = OUTS;
    localparam logic [Y_W-1:0] Y_MASK = (ACTIVE_LOW != 0) ? {Y_W{1'b1}} : '0;

    state_e          state_q;
    state_e          state_d;
    logic [Y_W-1:0]  y_q;
    logic [Y_W-1:0]  y_d;
    logic [Y_W-1:0]  y_act;
    logic [N-1:0]    sel_q;
    logic [N-1:0]    sel_d;
    logic            out_valid_q;
    logic            out_valid_d;
    logic            err_q;
    logic            err_d;

    logic            cnt_en;
    logic            cnt_clear;
    logic [N-1:0]    cnt_sel;
    logic [N-1:0]    cnt_sel_nxt;
    logic            cnt_step;

    // Counter restarts on the entry edge and only runs while scan persists.
    assign cnt_clear = en && mode && (state_q != SCAN);
    assign cnt_en    = en && mode && (state_q == SCAN);

    scan_step_counter #(
        .DIV   (DIV),
        .OUTS  (OUTS),
        .SEL_W (N)
    ) u_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (cnt_en),
        .clear   (cnt_clear),
        .sel     (cnt_sel),
        .sel_nxt (cnt_sel_nxt),
        .step    (cnt_step)
    );

    always_comb begin
        state_d     = state_q;
        y_act       = y_q ^ Y_MASK;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        err_d       = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (mode) begin
                        state_d     = SCAN;
                        y_act       = Y_W'(onehot(0, OUTS_U));
                        sel_d       = '0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = DIRECT;
                    end
                end
                DIRECT: begin
                    // A mode change wins over a handshake on the same edge.
                    if (mode) begin
                        state_d     = SCAN;
                        y_act       = Y_W'(onehot(0, OUTS_U));
                        sel_d       = '0;
                        out_valid_d = 1'b1;
                    end else if (in_valid) begin
                        sel_d = a;
                        y_act = Y_W'(onehot(32'(a), OUTS_U));
                        if (32'(a) >= OUTS_U) begin
                            out_valid_d = 1'b0;
                            err_d       = 1'b1;
                        end else begin
                            out_valid_d = 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        state_d = DIRECT;
                    end else begin
                        sel_d       = cnt_sel_nxt;
                        y_act       = Y_W'(onehot(32'(cnt_sel_nxt), OUTS_U));
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        y_d = y_act ^ Y_MASK;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= Y_MASK;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = en && (state_q == DIRECT);
    assign y         = y_q;
    assign sel       = (state_q == SCAN) ? cnt_sel : sel_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign step      = cnt_step;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder (N=3, OUTS=6, DIV=3, active-low outputs).
// Each step pushes its expected post-edge observation and pops it after the edge.
module tb_scan_decoder;

    localparam int N          = 3;
    localparam int OUTS       = 6;
    localparam int DIV        = 3;
    localparam int ACTIVE_LOW = 1;
    localparam int OBS_W      = 17;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           mode;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [7:0]     y;
    logic [N-1:0]   sel;
    logic           out_valid;
    logic           err;
    logic           step;
    logic [1:0]     dbg_state;

    logic [OBS_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int m_sel = 0;
    int m_div = 0;

    always #5 clk = ~clk;

    scan_decoder #(
        .N          (N),
        .OUTS       (OUTS),
        .DIV        (DIV),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .y         (y),
        .sel       (sel),
        .out_valid (out_valid),
        .err       (err),
        .step      (step),
        .dbg_state (dbg_state)
    );

    // Expected observation: {state, y, sel, out_valid, err, step, in_ready}.
    function automatic logic [OBS_W-1:0] ev(input logic [1:0] st, input int yi, input int s,
                                            input logic ov, input logic er,
                                            input logic stp, input logic rdy);
        logic [7:0] yv;
        yv = (yi >= 0 && yi < OUTS) ? 8'(1 << yi) : 8'h00;
        if (ACTIVE_LOW != 0) yv = ~yv;
        return {st, yv, 3'(s), ov, er, stp, rdy};
    endfunction

    task automatic check_cycle(input string tag, input logic [OBS_W-1:0] e);
        logic [OBS_W-1:0] obs;
        logic [OBS_W-1:0] want;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        obs  = {dbg_state, y, sel, out_valid, err, step, in_ready};
        want = exp_q.pop_front();
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
        @(negedge clk);
    endtask

    // Scan reference: advance on every enabled edge that stays in scan mode.
    task automatic scan_cycle(input string tag);
        if (en && mode) begin
            if (m_div == DIV - 1) begin
                m_div = 0;
                m_sel = (m_sel == OUTS - 1) ? 0 : m_sel + 1;
            end else begin
                m_div = m_div + 1;
            end
        end
        check_cycle(tag, ev(ST_SCAN, m_sel, m_sel, 1'b1, 1'b0,
                            en && mode && (m_div == DIV - 1), 1'b0));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; a = '0;
        @(negedge clk);
        check_cycle("reset", ev(ST_IDLE, -1, 0, 0, 0, 0, 0));
        en = 1'b1;
        check_cycle("reset_with_en", ev(ST_IDLE, -1, 0, 0, 0, 0, 0));

        rst_n = 1'b1;
        check_cycle("idle_to_direct", ev(ST_DIRECT, -1, 0, 0, 0, 0, 1));

        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 3'(i);
            check_cycle($sformatf("direct_a%0d", i),
                        ev(ST_DIRECT, i, i, i < OUTS, i >= OUTS, 0, 1));
        end
        in_valid = 1'b0; a = 3'd2;
        check_cycle("direct_hold_oor", ev(ST_DIRECT, -1, 7, 0, 0, 0, 1));
        in_valid = 1'b1; a = 3'd5;
        check_cycle("direct_a5_again", ev(ST_DIRECT, 5, 5, 1, 0, 0, 1));
        en = 1'b0; a = 3'd1;
        check_cycle("direct_en_low", ev(ST_DIRECT, 5, 5, 1, 0, 0, 0));
        en = 1'b1; in_valid = 1'b0;
        check_cycle("direct_hold", ev(ST_DIRECT, 5, 5, 1, 0, 0, 1));

        // Mode change together with a valid input: no capture, scan starts at 0.
        mode = 1'b1; in_valid = 1'b1; a = 3'd2;
        m_sel = 0; m_div = 0;
        check_cycle("enter_scan_over_handshake", ev(ST_SCAN, 0, 0, 1, 0, 0, 0));
        in_valid = 1'b0;
        for (int i = 0; i < 2 * OUTS * DIV; i++) scan_cycle("scan_sweep");

        for (int i = 0; i < OUTS * DIV && !(m_sel == 2 && m_div == 1); i++)
            scan_cycle("scan_seek_2");
        en = 1'b0;
        for (int i = 0; i < 5; i++) scan_cycle("scan_freeze");
        en = 1'b1;
        scan_cycle("scan_release_1");
        scan_cycle("scan_release_2");

        for (int i = 0; i < OUTS * DIV && m_sel != 3; i++) scan_cycle("scan_seek_3");
        rst_n = 1'b0;
        check_cycle("reset_mid_scan", ev(ST_IDLE, -1, 0, 0, 0, 0, 0));
        rst_n = 1'b1; en = 1'b0;
        check_cycle("idle_en_low", ev(ST_IDLE, -1, 0, 0, 0, 0, 0));

        en = 1'b1; mode = 1'b1; m_sel = 0; m_div = 0;
        check_cycle("idle_to_scan", ev(ST_SCAN, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) scan_cycle("scan_short");

        mode = 1'b0;
        check_cycle("scan_to_direct", ev(ST_DIRECT, m_sel, m_sel, 1, 0, 0, 1));
        check_cycle("direct_after_scan_hold", ev(ST_DIRECT, m_sel, m_sel, 1, 0, 0, 1));
        in_valid = 1'b1; a = 3'd4;
        check_cycle("direct_after_scan_a4", ev(ST_DIRECT, 4, 4, 1, 0, 0, 1));

        a = 3'd3; rst_n = 1'b0;
        check_cycle("reset_mid_handshake", ev(ST_IDLE, -1, 0, 0, 0, 0, 0));
        rst_n = 1'b1; in_valid = 1'b0;
        check_cycle("restart_direct", ev(ST_DIRECT, -1, 0, 0, 0, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
